// File: rtl/vga_sync_gen_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : vga_sync_gen_param
// Purpose  : Parametrised VGA timing generator with four registered pattern
//            modes; mode and colour are shadowed at frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module vga_sync_gen_param #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int BPC      = 1,
    parameter int CHK_LOG2 = 5,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW      = $clog2(H_TOTAL),
    localparam int YW      = $clog2(V_TOTAL),
    localparam int RGB_W   = 3 * BPC
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [RGB_W-1:0] ctrl_rgb,
    input  logic [1:0]       ctrl_mode,
    output logic [RGB_W-1:0] graph_rgb,
    output logic             h_sync,
    output logic             v_sync,
    output logic             video_on,
    output logic [XW-1:0]    pixel_x,
    output logic [YW-1:0]    pixel_y,
    output logic             frame_start
);

    localparam logic [XW-1:0] H_MAX    = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_C  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] H_LAST   = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [XW-1:0] BAR_W    = XW'(H_ACTIVE / 8);
    localparam logic [YW-1:0] V_MAX    = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_C  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] V_LAST   = YW'(V_ACTIVE - 1);
    localparam logic [YW-1:0] VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic pix_tick;

    generate
        if (CLK_DIV == 1) begin : g_div_bypass
            assign pix_tick = 1'b1;
        end else begin : g_div
            localparam int            DW      = $clog2(CLK_DIV);
            localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

            logic [DW-1:0] div_cnt_q, div_cnt_d;

            assign pix_tick = (div_cnt_q == DIV_MAX);

            always_comb begin
                div_cnt_d = div_cnt_q + 1'b1;
                if (pix_tick) begin
                    div_cnt_d = '0;
                end
            end

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    div_cnt_q <= '0;
                end else begin
                    div_cnt_q <= div_cnt_d;
                end
            end
        end
    endgenerate

    logic [XW-1:0]    h_cnt_q, h_cnt_d;
    logic [YW-1:0]    v_cnt_q, v_cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [RGB_W-1:0] color_q, color_d;
    logic [RGB_W-1:0] graph_rgb_q, graph_rgb_d;
    logic             h_sync_q, h_sync_d;
    logic             v_sync_q, v_sync_d;
    logic             video_on_q, video_on_d;
    logic [XW-1:0]    pixel_x_q, pixel_x_d;
    logic [YW-1:0]    pixel_y_q, pixel_y_d;
    logic             frame_start_q, frame_start_d;

    logic             origin;
    logic             active;
    logic             hs_act;
    logic             vs_act;
    logic             border;
    logic             chk_inv;
    logic [2:0]       bar_idx;
    logic [1:0]       eff_mode;
    logic [RGB_W-1:0] eff_rgb;
    logic [RGB_W-1:0] bar_rgb;
    logic [RGB_W-1:0] pix_rgb;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (pix_tick) begin
            if (h_cnt_q == H_MAX) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    // Pixel (0,0) bypasses the shadows so a new frame starts with fresh controls.
    always_comb begin
        origin   = (h_cnt_q == '0) && (v_cnt_q == '0);
        eff_mode = origin ? ctrl_mode : mode_q;
        eff_rgb  = origin ? ctrl_rgb  : color_q;
        active   = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        hs_act   = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_act   = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        border   = (h_cnt_q == '0) || (h_cnt_q == H_LAST) ||
                   (v_cnt_q == '0) || (v_cnt_q == V_LAST);
        chk_inv  = h_cnt_q[CHK_LOG2] ^ v_cnt_q[CHK_LOG2];
        bar_idx  = 3'(h_cnt_q / BAR_W);
        bar_rgb  = {{BPC{bar_idx[2]}}, {BPC{bar_idx[1]}}, {BPC{bar_idx[0]}}};

        pix_rgb = '0;
        if (active) begin
            case (eff_mode)
                2'b00:   pix_rgb = eff_rgb;
                2'b01:   pix_rgb = bar_rgb;
                2'b10:   pix_rgb = chk_inv ? ~eff_rgb : eff_rgb;
                default: pix_rgb = border ? {RGB_W{1'b1}} : eff_rgb;
            endcase
        end
    end

    always_comb begin
        mode_d        = mode_q;
        color_d       = color_q;
        graph_rgb_d   = graph_rgb_q;
        h_sync_d      = h_sync_q;
        v_sync_d      = v_sync_q;
        video_on_d    = video_on_q;
        pixel_x_d     = pixel_x_q;
        pixel_y_d     = pixel_y_q;
        frame_start_d = pix_tick && origin;
        if (pix_tick) begin
            if (origin) begin
                mode_d  = ctrl_mode;
                color_d = ctrl_rgb;
            end
            graph_rgb_d = pix_rgb;
            h_sync_d    = hs_act ? HS_POL : ~HS_POL;
            v_sync_d    = vs_act ? VS_POL : ~VS_POL;
            video_on_d  = active;
            pixel_x_d   = h_cnt_q;
            pixel_y_d   = v_cnt_q;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            mode_q        <= 2'b00;
            color_q       <= '0;
            graph_rgb_q   <= '0;
            h_sync_q      <= ~HS_POL;
            v_sync_q      <= ~VS_POL;
            video_on_q    <= 1'b0;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            mode_q        <= mode_d;
            color_q       <= color_d;
            graph_rgb_q   <= graph_rgb_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            video_on_q    <= video_on_d;
            pixel_x_q     <= pixel_x_d;
            pixel_y_q     <= pixel_y_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign graph_rgb   = graph_rgb_q;
    assign h_sync      = h_sync_q;
    assign v_sync      = v_sync_q;
    assign video_on    = video_on_q;
    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_gen_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_vga_sync_gen_param
// Purpose  : Randomised bench for vga_sync_gen_param against a pixel-index model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_sync_gen_param;

    // Shrunken timing keeps whole frames short; second instance uses defaults.
    localparam int DIV = 2;
    localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VSW = 2, VBP = 2;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam int BPC = 2, CHK = 2;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FR = HT * VT;
    localparam int RGBW = 3 * BPC;
    localparam int XW = $clog2(HT), YW = $clog2(VT);

    logic            clk;
    logic            rst_n;
    logic [RGBW-1:0] ctrl_rgb;
    logic [1:0]      ctrl_mode;
    logic [RGBW-1:0] graph_rgb;
    logic            h_sync, v_sync, video_on, frame_start;
    logic [XW-1:0]   pixel_x;
    logic [YW-1:0]   pixel_y;

    logic            rst1_n;
    logic [2:0]      ctrl_rgb1;
    logic [1:0]      ctrl_mode1;
    logic [2:0]      graph_rgb1;
    logic            h_sync1, v_sync1, video_on1, frame_start1;
    logic [9:0]      pixel_x1;
    logic [9:0]      pixel_y1;

    vga_sync_gen_param #(
        .CLK_DIV(DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HS_POL(HPOL), .VS_POL(VPOL), .BPC(BPC), .CHK_LOG2(CHK)
    ) u_dut (
        .CLK(clk), .RESET(rst_n), .ctrl_rgb(ctrl_rgb), .ctrl_mode(ctrl_mode),
        .graph_rgb(graph_rgb), .h_sync(h_sync), .v_sync(v_sync),
        .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .frame_start(frame_start)
    );

    vga_sync_gen_param #(.CLK_DIV(1)) u_dut_div1 (
        .CLK(clk), .RESET(rst1_n), .ctrl_rgb(ctrl_rgb1), .ctrl_mode(ctrl_mode1),
        .graph_rgb(graph_rgb1), .h_sync(h_sync1), .v_sync(v_sync1),
        .video_on(video_on1), .pixel_x(pixel_x1), .pixel_y(pixel_y1),
        .frame_start(frame_start1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: clocks since reset release -> pixel index -> expected outputs.
    int              k;
    int              frame_cnt;
    int              sh_mode;
    logic [RGBW-1:0] sh_rgb;
    logic [RGBW-1:0] e_rgb;
    logic            e_hs, e_vs, e_von, e_fs;
    int              e_x, e_y;

    function automatic logic [RGBW-1:0] model_rgb(input int x, input int y, input int mode,
                                                  input logic [RGBW-1:0] col);
        int ones;
        int bar;
        ones = (1 << BPC) - 1;
        if (x >= HA || y >= VA) return '0;
        case (mode)
            0: return col;
            1: begin
                bar = x / (HA / 8);
                return RGBW'(((bar / 4) % 2) * ones * (1 << (2 * BPC)) +
                             ((bar / 2) % 2) * ones * (1 << BPC) + (bar % 2) * ones);
            end
            2: return ((((x >> CHK) ^ (y >> CHK)) & 1) != 0) ? ~col : col;
            default: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? {RGBW{1'b1}} : col;
        endcase
    endfunction

    task automatic model_reset();
        k = 0; sh_mode = 0; sh_rgb = '0;
        e_rgb = '0; e_hs = ~HPOL; e_vs = ~VPOL; e_von = 1'b0; e_fs = 1'b0;
        e_x = 0; e_y = 0;
    endtask

    task automatic model_step();
        int p, x, y;
        k++;
        e_fs = 1'b0;
        if (k % DIV == 0) begin
            p = k / DIV - 1;
            x = p % HT;
            y = (p / HT) % VT;
            if (x == 0 && y == 0) begin
                sh_mode = int'(ctrl_mode);
                sh_rgb  = ctrl_rgb;
                e_fs    = 1'b1;
            end
            e_x   = x;
            e_y   = y;
            e_von = (x < HA) && (y < VA);
            e_hs  = (x >= HA + HFP && x < HA + HFP + HSW) ? HPOL : ~HPOL;
            e_vs  = (y >= VA + VFP && y < VA + VFP + VSW) ? VPOL : ~VPOL;
            e_rgb = model_rgb(x, y, sh_mode, sh_rgb);
        end
    endtask

    task automatic check_all();
        check_val("graph_rgb",   32'(graph_rgb),   32'(e_rgb));
        check_val("h_sync",      32'(h_sync),      32'(e_hs));
        check_val("v_sync",      32'(v_sync),      32'(e_vs));
        check_val("video_on",    32'(video_on),    32'(e_von));
        check_val("pixel_x",     32'(pixel_x),     32'(e_x));
        check_val("pixel_y",     32'(pixel_y),     32'(e_y));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
            // Next posedge is the origin tick: force each mode in turn there.
            if ((k + 1) % (DIV * FR) == DIV) begin
                ctrl_mode = 2'(frame_cnt % 4);
                ctrl_rgb  = RGBW'($urandom);
                frame_cnt++;
            end else if ($urandom_range(0, 99) < 4) begin
                ctrl_mode = 2'($urandom_range(0, 3));
                ctrl_rgb  = RGBW'($urandom);
            end
        end
    endtask

    int fall_t[3];
    int rise_t;
    int k1;
    int nf;
    logic prev_hs1;

    initial begin
        rst_n = 1'b1; rst1_n = 1'b1;
        ctrl_rgb = 6'b001100; ctrl_mode = 2'b00;
        ctrl_rgb1 = 3'b010; ctrl_mode1 = 2'b00;
        frame_cnt = 0;
        model_reset();
        #1;
        rst_n = 1'b0; rst1_n = 1'b0;
        #100;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        run_cycles(8 * FR * DIV + 301);

        // Asynchronous reset mid-frame, away from any clock edge.
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (3) begin
            @(negedge clk);
            check_all();
        end
        rst_n = 1'b1;
        run_cycles(2 * FR * DIV + 20);

        // Default-timing instance at one clock per pixel.
        @(negedge clk);
        check_val("div1_rst_hsync", 32'(h_sync1), 32'd1);
        check_val("div1_rst_vsync", 32'(v_sync1), 32'd1);
        check_val("div1_rst_von",   32'(video_on1), 32'd0);
        check_val("div1_rst_rgb",   32'(graph_rgb1), 32'd0);
        rst1_n = 1'b1;
        for (int i = 0; i < 3; i++) fall_t[i] = -1;
        rise_t = -1; k1 = 0; nf = 0; prev_hs1 = h_sync1;
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk);
            k1++;
            @(negedge clk);
            if (k1 == 1) begin
                check_val("div1_first_rgb", 32'(graph_rgb1),   32'h2);
                check_val("div1_first_fs",  32'(frame_start1), 32'd1);
            end
            if (prev_hs1 && !h_sync1 && nf < 3) begin
                fall_t[nf] = k1;
                nf++;
            end
            if (!prev_hs1 && h_sync1 && rise_t < 0) rise_t = k1;
            prev_hs1 = h_sync1;
        end
        check_val("div1_first_fall", 32'(fall_t[0]), 32'd657);
        check_val("div1_hs_low",     32'(rise_t - fall_t[0]), 32'd96);
        check_val("div1_hs_period0", 32'(fall_t[1] - fall_t[0]), 32'd800);
        check_val("div1_hs_period1", 32'(fall_t[2] - fall_t[1]), 32'd800);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_sync_gen_param.md
Name: vga_sync_gen_param

Overview:
Parametrised VGA timing and pixel generator, the next generation of the fixed 640x480 controller. Generates h_sync/v_sync, video_on and pixel coordinates from a clock-enable divider off the system clock. Drives a registered colour output from one of four pattern modes: solid, colour bars, checkerboard or border. Mode and colour are shadowed so they change only at frame boundaries. Sits between the colour/control logic and the VGA connector.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1; 2 gives 25 MHz from 50 MHz)
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BP, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BP, 33, vertical back porch, lines
HS_POL, 0, h_sync active level (0 = active-low)
VS_POL, 0, v_sync active level
BPC, 1, bits per colour channel; RGB_W = 3*BPC
CHK_LOG2, 5, checker square size = 2^CHK_LOG2 pixels
Derived: H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; XW = clog2(H_TOTAL); YW = clog2(V_TOTAL)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
ctrl_rgb  in  RGB_W  base colour {R,G,B}, MSB = R
ctrl_mode  in  2  00 solid, 01 bars, 10 checker, 11 border
graph_rgb  out  RGB_W  pixel colour, zero in blanking
h_sync  out  1  horizontal sync
v_sync  out  1  vertical sync
video_on  out  1  visible-area flag
pixel_x  out  XW  current output pixel column
pixel_y  out  YW  current output pixel row
frame_start  out  1  one-CLK pulse marking the first pixel (0,0) of a frame

Behaviour:
- Reset (RESET=0, asynchronous, takes effect without a clock edge):
  - div_cnt, h_cnt, v_cnt, pixel_x, pixel_y and graph_rgb go to 0.
  - video_on and frame_start go to 0.
  - h_sync = ~HS_POL and v_sync = ~VS_POL (inactive levels).
  - Shadow mode = 00, shadow colour = 0.
- Divider:
  - div_cnt counts 0..CLK_DIV-1; pix_tick = (div_cnt == CLK_DIV-1).
  - With CLK_DIV = 1, pix_tick is 1 every cycle.
- Counters advance only on pix_tick:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments on an h_cnt wrap, and wraps to 0 after V_TOTAL-1.
- Decode of the current (h,v):
  - active = h < H_ACTIVE && v < V_ACTIVE.
  - hs_act = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs_act = V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
- Output registers:
  - All outputs load together on pix_tick from the decode of the pre-increment counters.
  - Latency: outputs lag the counters by exactly one pixel period.
  - Output levels: h_sync = hs_act ? HS_POL : ~HS_POL; v_sync likewise with VS_POL.
  - pixel_x = h, pixel_y = v.
- Shadow registers:
  - On the pix_tick where h=0 and v=0, ctrl_mode and ctrl_rgb are sampled into the shadows.
  - That same pixel (0,0) already uses the new values (bypass).
  - Input changes at any other time have no effect until the next frame.
- frame_start: high for exactly the one CLK cycle after the tick that loads pixel (0,0).
- Colour, evaluated only when active; otherwise graph_rgb = 0:
  - 00: shadow colour.
  - 01: bar index i = h / (H_ACTIVE/8), range 0..7. R = {BPC{i[2]}}, G = {BPC{i[1]}}, B = {BPC{i[0]}}.
  - 10: shadow colour when h[CHK_LOG2] ^ v[CHK_LOG2] = 0, else its bitwise inverse.
  - 11: all ones when h = 0, h = H_ACTIVE-1, v = 0 or v = V_ACTIVE-1; else shadow colour.
- Release from reset: counting restarts at (0,0); the first tick loads pixel (0,0) and pulses frame_start.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clocks. Default = 840000 clocks = 16.8 ms at 50 MHz.

Test Plan:
1. Reset/sync timing (defaults, 50 MHz, ctrl_rgb=010, mode 00): hold RESET=0 for 100 ns.
   - During reset: all outputs at reset values, h_sync=v_sync=1.
   - After release: h_sync period 32.0 us with a 3.84 us low pulse; v_sync period 16.8 ms with a 64 us low pulse.
   - graph_rgb=010 exactly when video_on=1, else 000.
2. Counting over one frame: video_on high for 307200 ticks; frame_start once per 840000 CLK.
   - pixel_x reaches 799 and wraps; pixel_y reaches 524 and wraps.
3. Mode change mid-frame: switch to mode 01 at pixel_y=100 -> current frame stays 010 until the next frame_start.
   - Next frame: x 0-79 -> 000, 80-159 -> 001, ..., 560-639 -> 111.
4. Checker (ctrl_rgb=101, mode 10) -> pixel (0,0)=101, (32,0)=010, (32,32)=101, (31,63)=010.
5. Border (ctrl_rgb=011, mode 11) -> (0,5)=111, (639,479)=111, (5,0)=111, (5,5)=011.
6. Reset and divider:
   - Assert RESET at pixel_y=200 mid-line -> outputs reach reset values before the next CLK edge.
   - After release: frame restarts, first frame_start 1 tick later.
   - Separate instance with CLK_DIV=1 -> h_sync period 800 CLK (16 us).
